// File: rtl/version_pkg.sv
// Build identification fields consumed by the version streamer (BCD timestamp).
package version_pkg;

  localparam logic [7:0]  VERSION_MAJOR  = 8'd0;
  localparam logic [7:0]  VERSION_MINOR  = 8'd0;
  localparam logic [7:0]  VERSION_PATCH  = 8'd0;
  localparam logic [7:0]  VERSION_BUILD  = 8'd65;
  localparam logic [15:0] VERSION_YEAR   = 16'h2025;
  localparam logic [7:0]  VERSION_MONTH  = 8'h11;
  localparam logic [7:0]  VERSION_DAY    = 8'h10;
  localparam logic [7:0]  VERSION_HOUR   = 8'h11;
  localparam logic [7:0]  VERSION_MINUTE = 8'h22;
  localparam logic [7:0]  VERSION_SECOND = 8'h55;

endpackage

// File: rtl/version_stream_pkg.sv
// Shared constants and types for the version frame streamer.
package version_stream_pkg;

  localparam int unsigned FRAME_LEN_BASE  = 12;
  localparam int unsigned FRAME_LEN_CKSUM = 13;
  localparam int unsigned IDX_W           = 4;

  typedef logic [IDX_W-1:0] vs_idx_t;

  typedef enum logic {
    VS_IDLE = 1'b0,
    VS_SEND = 1'b1
  } vs_state_e;

  localparam logic [7:0] VS_SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/version_frame_mux.sv
// Combinational frame-index to byte selector for the version frame.
// Optional macro VERSION_STREAMER_CHECKSUM_EN adds the checksum byte at index 12.
module version_frame_mux
  import version_stream_pkg::*;
  import version_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = VS_SYNC_DEFAULT
) (
  input  logic [IDX_W-1:0] idx,
`ifdef VERSION_STREAMER_CHECKSUM_EN
  input  logic [7:0]       cksum,
`endif
  output logic [7:0]       frame_byte_c
);

  // Map frame position to its field value; unused positions read as zero.
  always_comb begin
    frame_byte_c = 8'h00;
    case (idx)
      4'd0:  frame_byte_c = SYNC_BYTE;
      4'd1:  frame_byte_c = VERSION_MAJOR;
      4'd2:  frame_byte_c = VERSION_MINOR;
      4'd3:  frame_byte_c = VERSION_PATCH;
      4'd4:  frame_byte_c = VERSION_BUILD;
      4'd5:  frame_byte_c = VERSION_YEAR[15:8];
      4'd6:  frame_byte_c = VERSION_YEAR[7:0];
      4'd7:  frame_byte_c = VERSION_MONTH;
      4'd8:  frame_byte_c = VERSION_DAY;
      4'd9:  frame_byte_c = VERSION_HOUR;
      4'd10: frame_byte_c = VERSION_MINUTE;
      4'd11: frame_byte_c = VERSION_SECOND;
`ifdef VERSION_STREAMER_CHECKSUM_EN
      4'd12: frame_byte_c = cksum;
`endif
      default: frame_byte_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/version_streamer.sv
// Streams the build identification frame over a valid/ready byte interface.
// Optional macro VERSION_STREAMER_CHECKSUM_EN appends an XOR checksum byte.
module version_streamer
  import version_stream_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = VS_SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  input  logic       m_ready_i
);

`ifdef VERSION_STREAMER_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CKSUM;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam vs_idx_t LAST_IDX = IDX_W'(FRAME_LEN - 1);

  vs_state_e  state_q, state_d;
  vs_idx_t    idx_q, idx_d;
  logic       done_d;
  logic [7:0] mux_byte_c;
  logic [7:0] data_d;
`ifdef VERSION_STREAMER_CHECKSUM_EN
  logic [7:0] cksum_q, cksum_d;
`endif

  // Byte for the index that will be presented after the next edge.
  version_frame_mux #(
    .SYNC_BYTE(SYNC_BYTE)
  ) u_mux (
    .idx         (idx_d),
`ifdef VERSION_STREAMER_CHECKSUM_EN
    .cksum       (cksum_d),
`endif
    .frame_byte_c(mux_byte_c)
  );

  // Next-state, index, checksum and output-data decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef VERSION_STREAMER_CHECKSUM_EN
    cksum_d = cksum_q;
`endif
    case (state_q)
      VS_IDLE: begin
        if (req_i) begin
          state_d = VS_SEND;
          idx_d   = '0;
`ifdef VERSION_STREAMER_CHECKSUM_EN
          cksum_d = 8'h00;
`endif
        end
      end
      VS_SEND: begin
        if (m_valid_o && m_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = VS_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
`ifdef VERSION_STREAMER_CHECKSUM_EN
            // SYNC is excluded; the checksum byte itself is the last index.
            if (idx_q != '0) begin
              cksum_d = cksum_q ^ m_data_o;
            end
`endif
          end
        end
      end
      default: state_d = VS_IDLE;
    endcase
    data_d = (state_d == VS_SEND) ? mux_byte_c : 8'h00;
  end

  // State, index and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= VS_IDLE;
      idx_q     <= '0;
      busy_o    <= 1'b0;
      m_valid_o <= 1'b0;
      done_o    <= 1'b0;
      m_data_o  <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_o    <= (state_d == VS_SEND);
      m_valid_o <= (state_d == VS_SEND);
      done_o    <= done_d;
      m_data_o  <= data_d;
    end
  end

`ifdef VERSION_STREAMER_CHECKSUM_EN
  // Running XOR of accepted payload bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum_q <= 8'h00;
    end else begin
      cksum_q <= cksum_d;
    end
  end
`endif

endmodule

// File: tb/tb_version_streamer.sv
// Scoreboard bench for version_streamer: stimulus queues expected bytes,
// a negedge monitor pops and compares on every handshake.
module tb_version_streamer;

`ifdef VERSION_STREAMER_CHECKSUM_EN
  localparam int FLEN = 13;
`else
  localparam int FLEN = 12;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         hs_count      = 0;
  int         done_count    = 0;
  int         pos_in_frame  = 0;
  bit         done_expected = 1'b0;
  bit         stall_pending = 1'b0;
  logic [7:0] stall_data    = 8'h00;
  bit         rand_ready    = 1'b0;

  always #5 clk = ~clk;

  version_streamer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .m_data_o (m_data_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

  // Hand-computed frame: build 65, 2025-11-10 11:22:55, checksum 0x23.
  function automatic logic [7:0] frame_byte(input int i);
    case (i)
      0:  return 8'hA5;
      1:  return 8'h00;
      2:  return 8'h00;
      3:  return 8'h00;
      4:  return 8'h41;
      5:  return 8'h20;
      6:  return 8'h25;
      7:  return 8'h11;
      8:  return 8'h10;
      9:  return 8'h11;
      10: return 8'h22;
      11: return 8'h55;
      12: return 8'h23;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < FLEN; i++) exp_q.push_back(frame_byte(i));
  endtask

  task automatic pulse_req();
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      if (rand_ready) m_ready_i = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("done_within_budget", 8'(done_o), 8'd1);
  endtask

  // Monitor: protocol invariants, stall stability, scoreboard pop, done placement.
  always @(negedge clk) begin
    if (!rst_n) begin
      pos_in_frame  = 0;
      done_expected = 1'b0;
      stall_pending = 1'b0;
    end else begin
      check("busy_eq_valid", 8'(busy_o), 8'(m_valid_o));
      if (!m_valid_o) check("idle_data_zero", m_data_o, 8'h00);
      if (stall_pending) begin
        check("stall_valid_held", 8'(m_valid_o), 8'd1);
        check("stall_data_held", m_data_o, stall_data);
      end
      check("done_placement", 8'(done_o), 8'(done_expected));
      if (done_o) begin
        check("busy_low_in_done", 8'(busy_o), 8'd0);
        done_count++;
      end
      done_expected = 1'b0;
      if (m_valid_o && m_ready_i) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", m_data_o, 8'hxx);
        end else begin
          check("stream_byte", m_data_o, exp_q.pop_front());
        end
        if (pos_in_frame == FLEN - 1) begin
          pos_in_frame  = 0;
          done_expected = 1'b1;
        end else begin
          pos_in_frame++;
        end
      end
      stall_pending = m_valid_o && !m_ready_i;
      stall_data    = m_data_o;
    end
  end

  initial begin
    int base_done;
    int base_hs;
    int n;

    rst_n     = 1'b0;
    req_i     = 1'b0;
    m_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 8'(busy_o), 8'd0);
    check("rst_valid", 8'(m_valid_o), 8'd0);
    check("rst_data", m_data_o, 8'h00);
    check("rst_done", 8'(done_o), 8'd0);
    rst_n = 1'b1;
    tick();

    // Single frame with exact cycle timing.
    push_frame();
    pulse_req();
    for (int c = 1; c <= FLEN + 2; c++) begin
      check("single_valid_timing", 8'(m_valid_o), 8'(c <= FLEN));
      check("single_done_timing", 8'(done_o), 8'(c == FLEN + 1));
      if (c == 1) check("first_byte_sync", m_data_o, 8'hA5);
      tick();
    end

    // Random backpressure.
    base_done = done_count;
    push_frame();
    rand_ready = 1'b1;
    pulse_req();
    wait_done(400);
    rand_ready = 1'b0;
    m_ready_i  = 1'b1;
    repeat (3) tick();
    check("bp_one_done", 8'(done_count - base_done), 8'd1);
    check("bp_queue_empty", 8'(exp_q.size()), 8'd0);

    // Request while busy is ignored.
    base_done = done_count;
    base_hs   = hs_count;
    push_frame();
    pulse_req();
    repeat (4) tick();
    pulse_req();
    wait_done(40);
    repeat (5) tick();
    check("busy_req_one_done", 8'(done_count - base_done), 8'd1);
    check("busy_req_bytes", 8'(hs_count - base_hs), 8'(FLEN));
    check("busy_req_idle", 8'(m_valid_o), 8'd0);

    // Request coincident with done starts the next frame immediately.
    base_done = done_count;
    push_frame();
    pulse_req();
    wait_done(40);
    push_frame();
    pulse_req();
    check("b2b_valid", 8'(m_valid_o), 8'd1);
    check("b2b_sync", m_data_o, 8'hA5);
    wait_done(40);
    repeat (3) tick();
    check("b2b_two_done", 8'(done_count - base_done), 8'd2);

    // Reset mid-frame aborts without done.
    base_done = done_count;
    base_hs   = hs_count;
    push_frame();
    pulse_req();
    n = 0;
    while ((hs_count - base_hs) < 7 && n < 100) begin
      tick();
      n++;
    end
    check("reach_byte7", 8'(hs_count - base_hs), 8'd7);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 8'(m_valid_o), 8'd0);
    check("abort_busy", 8'(busy_o), 8'd0);
    check("abort_data", m_data_o, 8'h00);
    check("abort_done", 8'(done_o), 8'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("abort_no_done", 8'(done_count - base_done), 8'd0);
    push_frame();
    pulse_req();
    check("restart_sync", m_data_o, 8'hA5);
    wait_done(40);
    repeat (3) tick();
    check("restart_one_done", 8'(done_count - base_done), 8'd1);

    // Idle quiet.
    for (int c = 0; c < 100; c++) begin
      if (m_valid_o || busy_o || done_o || (m_data_o != 8'h00)) begin
        check("quiet_valid", 8'(m_valid_o), 8'd0);
        check("quiet_busy", 8'(busy_o), 8'd0);
        check("quiet_done", 8'(done_o), 8'd0);
        check("quiet_data", m_data_o, 8'h00);
      end
      tick();
    end
    check("quiet_final_valid", 8'(m_valid_o), 8'd0);
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
